ifu_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the control decoder. It owns the PC register and fetches one 32-bit instruction at a time over a valid/ready instruction-memory port. It presents the instruction word and its PC to decode; decode slices bits [6:0] as op. After the stage commits, the fetch stage selects the next PC from the decoder's pc_src encoding.

---
 rtl/ifu_fetch.sv | 99 +++++++++
 tb/tb_ifu_fetch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: owns the PC, fetches one word per
// instruction over a valid/ready port and hands it to decode until execute commits.
module ifu_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    input  logic            commit_valid,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_EXEC = 2'd3
    } state_e;

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] BIT0_CLR = ~XLEN'(1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] next_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    // pc_src 11 is reserved and falls back to sequential flow.
    always_comb begin
        next_pc = pc_q + PC_STEP;
        case (pc_src)
            2'b01:   next_pc = pc_q + imm;
            2'b10:   next_pc = alu_result & BIT0_CLR;
            default: next_pc = pc_q + PC_STEP;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        case (state_q)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    inst_d  = imem_rsp_data;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (commit_valid) begin
                    pc_d    = next_pc;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Request is held off while rst is high so nothing escapes during reset.
    assign imem_req_valid = (state_q == S_REQ) && !rst;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == S_HOLD) && !rst;
    assign inst           = inst_q;
    assign pc             = pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed and randomized bench for ifu_fetch against a
// transaction-level PC/instruction model.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        commit_valid = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] imm = 32'd0;
    logic [31:0] alu_result = 32'd0;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc   = RESET_PC;
    logic [31:0] m_inst = 32'd0;

    ifu_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .commit_valid   (commit_valid),
        .pc_src         (pc_src),
        .imm            (imm),
        .alu_result     (alu_result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rule, stated arithmetically.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] src,
                                               input logic [31:0] im, input logic [31:0] alu);
        logic [63:0] sum;
        case (src)
            2'b01:   sum = {32'd0, cur} + {32'd0, im};
            2'b10:   sum = {32'd0, alu - (alu % 2)};
            default: sum = {32'd0, cur} + 64'd4;
        endcase
        return sum[31:0];
    endfunction

    // One full instruction: request, response, decode handshake, commit.
    // Stray inputs are injected while each phase is stalled.
    task automatic fetch_one(input logic [31:0] data, input int req_dly, input int rsp_dly,
                             input int rdy_dly, input int cmt_dly, input logic [1:0] src,
                             input logic [31:0] imm_v, input logic [31:0] alu_v);
        for (int i = 0; i < req_dly; i++) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            commit_valid   = 1'($urandom_range(0, 1));
            inst_ready     = 1'($urandom_range(0, 1));
            #1;
            check("req_valid_stall", 32'(imem_req_valid), 32'd1);
            check("req_addr_stall", imem_req_addr, m_pc);
            check("req_inst_stable", inst, m_inst);
            check("req_pc_stable", pc, m_pc);
            check("req_no_inst_valid", 32'(inst_valid), 32'd0);
            tick();
        end
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'($urandom_range(0, 1));
        imem_rsp_data  = $urandom;
        commit_valid   = 1'b0;
        inst_ready     = 1'b0;
        #1;
        check("req_valid", 32'(imem_req_valid), 32'd1);
        check("req_addr", imem_req_addr, m_pc);
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            imem_rsp_valid = 1'b0;
            commit_valid   = 1'($urandom_range(0, 1));
            inst_ready     = 1'($urandom_range(0, 1));
            #1;
            check("wait_req_low", 32'(imem_req_valid), 32'd0);
            check("wait_inst_valid_low", 32'(inst_valid), 32'd0);
            check("wait_inst_stable", inst, m_inst);
            tick();
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        commit_valid   = 1'b0;
        inst_ready     = 1'b0;
        #1;
        check("rsp_req_low", 32'(imem_req_valid), 32'd0);
        check("rsp_inst_valid_low", 32'(inst_valid), 32'd0);
        tick();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < rdy_dly; i++) begin
            inst_ready     = 1'b0;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            commit_valid   = 1'($urandom_range(0, 1));
            imem_req_ready = 1'($urandom_range(0, 1));
            #1;
            check("hold_inst_valid", 32'(inst_valid), 32'd1);
            check("hold_inst", inst, data);
            check("hold_pc", pc, m_pc);
            check("hold_no_req", 32'(imem_req_valid), 32'd0);
            tick();
        end
        inst_ready     = 1'b1;
        imem_rsp_valid = 1'b0;
        commit_valid   = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        check("hs_inst_valid", 32'(inst_valid), 32'd1);
        check("hs_inst", inst, data);
        check("hs_pc", pc, m_pc);
        tick();
        inst_ready = 1'b0;
        for (int i = 0; i < cmt_dly; i++) begin
            commit_valid   = 1'b0;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            pc_src         = 2'($urandom_range(0, 3));
            #1;
            check("exec_inst_valid_low", 32'(inst_valid), 32'd0);
            check("exec_inst", inst, data);
            check("exec_pc", pc, m_pc);
            check("exec_no_req", 32'(imem_req_valid), 32'd0);
            tick();
        end
        commit_valid   = 1'b1;
        imem_rsp_valid = 1'b0;
        pc_src         = src;
        imm            = imm_v;
        alu_result     = alu_v;
        #1;
        check("commit_inst_valid_low", 32'(inst_valid), 32'd0);
        tick();
        commit_valid = 1'b0;
        m_inst = data;
        m_pc   = model_next(m_pc, src, imm_v, alu_v);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b0;
        commit_valid   = 1'b0;
        #1;
        m_pc   = RESET_PC;
        m_inst = 32'd0;
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd1);
        check({tag, "_addr"}, imem_req_addr, RESET_PC);
        check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_inst"}, inst, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_pc", pc, RESET_PC);
        check("rst_inst", inst, 32'd0);
        rst = 1'b0;

        // Zero-wait latency followed by three sequential commits.
        fetch_one(32'h0010_0093, 0, 0, 0, 0, 2'b00, 32'd0, 32'd0);
        check("model_seq_pc1", m_pc, 32'h8000_0004);
        fetch_one(32'h0020_0113, 0, 0, 0, 0, 2'b00, 32'd0, 32'd0);
        fetch_one(32'h0030_0193, 0, 0, 0, 0, 2'b00, 32'd0, 32'd0);
        fetch_one(32'h0040_0213, 0, 0, 0, 0, 2'b00, 32'd0, 32'd0);

        // Branch with negative immediate from 0x8000_0010, then jalr.
        fetch_one(32'hFE00_08E3, 0, 1, 0, 1, 2'b01, 32'hFFFF_FFF0, 32'd0);
        fetch_one(32'h0000_8067, 1, 0, 1, 0, 2'b10, 32'd0, 32'h8000_0105);
        fetch_one(32'h0000_8067, 0, 0, 0, 0, 2'b10, 32'd0, 32'hFFFF_FFFD);
        fetch_one(32'h0000_0013, 0, 0, 0, 0, 2'b00, 32'd0, 32'd0);

        // Wrapped PC, with request and decode backpressure.
        fetch_one(32'h1234_5678, 3, 2, 5, 2, 2'b11, 32'd0, 32'd0);

        // Reset while waiting for a response.
        imem_req_ready = 1'b1;
        #1;
        check("rw_req_addr", imem_req_addr, m_pc);
        tick();
        imem_req_ready = 1'b0;
        pulse_reset("rst_wait");

        // Reset while in execute.
        fetch_one(32'hAAAA_5555, 0, 0, 0, 0, 2'b00, 32'd0, 32'd0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b1;
        #1;
        check("re_hold_inst", inst, 32'hDEAD_BEEF);
        tick();
        inst_ready = 1'b0;
        pulse_reset("rst_exec");

        for (int n = 0; n < 60; n++) begin
            fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      2'($urandom_range(0, 3)), $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
